// File: rtl/spice_node_bank.sv
// rtl/spice_node_bank.sv - bank of CH clamped fixed-point node integrators with settle detect
module spice_node_bank #(
  parameter int W      = 16,
  parameter int N      = 4,
  parameter int CH     = 2,
  parameter int CSHIFT = 2,
  parameter int VMAX   = 16383,
  parameter int VMIN   = -16384,
  parameter int TOL    = 0,
  parameter int SETTLE = 8
) (
  input  logic              eclk,
  input  logic              ereset_n,
  input  logic              step,
  input  logic [CH-1:0]     load,
  input  logic [CH*W-1:0]   v_init,
  input  logic [CH*N*W-1:0] i_in,
  output logic [CH*W-1:0]   v,
  output logic [CH-1:0]     p,
  output logic [CH-1:0]     sat,
  output logic [CH-1:0]     settled,
  output logic              all_settled
);

  // Sum width leaves headroom so adding N full-scale inputs can never wrap.
  localparam int SW = W + $clog2(N) + 1;
  // One more bit for v + dv so the clamp sees the true candidate.
  localparam int NW = SW + 1;
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic signed [NW-1:0] VMAX_N  = NW'(VMAX);
  localparam logic signed [NW-1:0] VMIN_N  = NW'(VMIN);
  localparam logic signed [W-1:0]  VMAX_W  = W'(VMAX);
  localparam logic signed [W-1:0]  VMIN_W  = W'(VMIN);
  localparam logic signed [SW-1:0] TOL_P   = SW'(TOL);
  localparam logic signed [SW-1:0] TOL_N   = SW'(-TOL);
  localparam logic [CW-1:0]        CNT_MAX = CW'(SETTLE);

  logic signed [W-1:0]  v_q   [CH];
  logic signed [W-1:0]  v_d   [CH];
  logic [CW-1:0]        cnt_q [CH];
  logic [CW-1:0]        cnt_d [CH];
  logic [CH-1:0]        sat_q;
  logic [CH-1:0]        sat_d;

  logic signed [SW-1:0] sum   [CH];
  logic signed [SW-1:0] dv    [CH];
  logic signed [NW-1:0] nxt   [CH];
  logic signed [W-1:0]  vclmp [CH];
  logic [CH-1:0]        clip;
  logic [CH-1:0]        still;

  // Datapath: sum currents, scale by capacitance, form and clamp candidate voltage.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum[c] = '0;
      for (int k = 0; k < N; k++) begin
        sum[c] = sum[c] + {{(SW-W){i_in[(c*N+k)*W + W-1]}}, i_in[(c*N+k)*W +: W]};
      end
      dv[c]  = sum[c] >>> CSHIFT;
      nxt[c] = {{(NW-W){v_q[c][W-1]}}, v_q[c]} + {dv[c][SW-1], dv[c]};
      if (nxt[c] > VMAX_N) begin
        vclmp[c] = VMAX_W;
        clip[c]  = 1'b1;
      end else if (nxt[c] < VMIN_N) begin
        vclmp[c] = VMIN_W;
        clip[c]  = 1'b1;
      end else begin
        vclmp[c] = nxt[c][W-1:0];
        clip[c]  = 1'b0;
      end
      // Movement is judged on dv itself, so a node pinned at a rail keeps moving.
      still[c] = (dv[c] <= TOL_P) && (dv[c] >= TOL_N);
    end
  end

  // Next state: load beats step per node; otherwise hold.
  always_comb begin
    sat_d = sat_q;
    for (int c = 0; c < CH; c++) begin
      v_d[c]   = v_q[c];
      cnt_d[c] = cnt_q[c];
      if (load[c]) begin
        v_d[c]   = v_init[c*W +: W];
        cnt_d[c] = '0;
        sat_d[c] = 1'b0;
      end else if (step) begin
        v_d[c]   = vclmp[c];
        sat_d[c] = sat_q[c] | clip[c];
        if (!still[c]) begin
          cnt_d[c] = '0;
        end else if (cnt_q[c] != CNT_MAX) begin
          cnt_d[c] = cnt_q[c] + CW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      sat_q <= '0;
      for (int c = 0; c < CH; c++) begin
        v_q[c]   <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      sat_q <= sat_d;
      for (int c = 0; c < CH; c++) begin
        v_q[c]   <= v_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      v[c*W +: W] = v_q[c];
      p[c]        = ~v_q[c][W-1];
      settled[c]  = (cnt_q[c] == CNT_MAX);
    end
    sat         = sat_q;
    all_settled = &settled;
  end

endmodule

// File: tb/tb_spice_node_bank.sv
// tb/tb_spice_node_bank.sv - directed table-driven bench for spice_node_bank
module tb_spice_node_bank;

  logic         eclk = 1'b0;
  logic         ereset_n;
  logic         step;
  logic [1:0]   load;
  logic [31:0]  v_init;
  logic [127:0] i_in;
  logic [31:0]  v;
  logic [1:0]   p;
  logic [1:0]   sat;
  logic [1:0]   settled;
  logic         all_settled;

  int errors = 0;
  int checks = 0;

  always #5 eclk = ~eclk;

  spice_node_bank dut (
    .eclk        (eclk),
    .ereset_n    (ereset_n),
    .step        (step),
    .load        (load),
    .v_init      (v_init),
    .i_in        (i_in),
    .v           (v),
    .p           (p),
    .sat         (sat),
    .settled     (settled),
    .all_settled (all_settled)
  );

  typedef struct {
    logic               rst_n;
    logic               stp;
    logic [1:0]         ld;
    logic signed [15:0] vi0;
    logic signed [15:0] vi1;
    logic signed [15:0] a0, a1, a2, a3;
    logic signed [15:0] b0;
    logic signed [15:0] ev0;
    logic signed [15:0] ev1;
    logic [1:0]         esat;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] l,
                              input logic signed [15:0] vi0, input logic signed [15:0] vi1,
                              input logic signed [15:0] a0, input logic signed [15:0] a1,
                              input logic signed [15:0] a2, input logic signed [15:0] a3,
                              input logic signed [15:0] b0,
                              input logic signed [15:0] ev0, input logic signed [15:0] ev1,
                              input logic [1:0] es);
    vec_t t;
    t.rst_n = r; t.stp = s; t.ld = l; t.vi0 = vi0; t.vi1 = vi1;
    t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3; t.b0 = b0;
    t.ev0 = ev0; t.ev1 = ev1; t.esat = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] l,
                       input logic signed [15:0] vi0, input logic signed [15:0] vi1,
                       input logic signed [15:0] a0, input logic signed [15:0] a1,
                       input logic signed [15:0] a2, input logic signed [15:0] a3,
                       input logic signed [15:0] b0);
    ereset_n = r;
    step     = s;
    load     = l;
    v_init   = {vi1, vi0};
    i_in     = {16'sd0, 16'sd0, 16'sd0, b0, a3, a2, a1, a0};
    @(posedge eclk);
    #1;
  endtask

  initial begin
    logic signed [15:0] e0, e1;
    //               rst stp ld     vi0     vi1  a0     a1     a2     a3     b0    ev0     ev1  esat
    tbl[0]  = mk(1'b0, 1'b1, 2'b11,    500,  500,     0,     0,     0,     0,    0,      0,   0, 2'b00);
    tbl[1]  = mk(1'b1, 1'b0, 2'b01,    100,    0,     0,     0,     0,     0,    0,    100,   0, 2'b00);
    tbl[2]  = mk(1'b1, 1'b1, 2'b00,      0,    0,    40,    40,     0,     0,    0,    120,   0, 2'b00);
    tbl[3]  = mk(1'b1, 1'b1, 2'b00,      0,    0,    -5,     0,     0,     0,    0,    118,   0, 2'b00);
    tbl[4]  = mk(1'b1, 1'b0, 2'b01,  16000,    0,     0,     0,     0,     0,    0,  16000,   0, 2'b00);
    tbl[5]  = mk(1'b1, 1'b1, 2'b00,      0,    0,  2000,  2000,  2000,  2000,    0,  16383,   0, 2'b01);
    tbl[6]  = mk(1'b1, 1'b1, 2'b00,      0,    0,     0,     0,     0,     0,    0,  16383,   0, 2'b01);
    tbl[7]  = mk(1'b1, 1'b0, 2'b01,      0,    0,     0,     0,     0,     0,    0,      0,   0, 2'b00);
    tbl[8]  = mk(1'b1, 1'b0, 2'b01, -16000,    0,     0,     0,     0,     0,    0, -16000,   0, 2'b00);
    tbl[9]  = mk(1'b1, 1'b1, 2'b00,      0,    0, -2000, -2000, -2000, -2000,    0, -16384,   0, 2'b01);
    tbl[10] = mk(1'b1, 1'b0, 2'b01,      0,    0,     0,     0,     0,     0,    0,      0,   0, 2'b00);
    tbl[11] = mk(1'b1, 1'b0, 2'b01,     50,    0,     0,     0,     0,     0,    0,     50,   0, 2'b00);
    tbl[12] = mk(1'b1, 1'b1, 2'b01,      7,  999,   400,     0,     0,     0,  400,      7, 100, 2'b00);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].stp, tbl[i].ld, tbl[i].vi0, tbl[i].vi1,
            tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].b0);
      e0 = tbl[i].ev0;
      e1 = tbl[i].ev1;
      chk($sformatf("v[%0d]", i), v, {e1, e0});
      chk($sformatf("p[%0d]", i), 32'(p), 32'({~e1[15], ~e0[15]}));
      chk($sformatf("sat[%0d]", i), 32'(sat), 32'(tbl[i].esat));
      chk($sformatf("settled[%0d]", i), 32'(settled), 32'd0);
      chk($sformatf("all_settled[%0d]", i), 32'(all_settled), 32'd0);
    end

    // Settle: both nodes see zero current; node0 = 7, node1 = 100.
    for (int s = 1; s <= 8; s++) begin
      drive(1'b1, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      if (s == 7) begin
        chk("settled_after7", 32'(settled), 32'd0);
        chk("all_after7", 32'(all_settled), 32'd0);
      end
    end
    chk("settled_after8", 32'(settled), 32'd3);
    chk("all_after8", 32'(all_settled), 32'd1);
    chk("v_settled", v, {16'sd100, 16'sd7});

    // A dv of 1 on node1 knocks only node1 out of settled.
    drive(1'b1, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 4);
    chk("settled_kick", 32'(settled), 32'd1);
    chk("all_kick", 32'(all_settled), 32'd0);
    chk("v_kick", v, {16'sd101, 16'sd7});

    // Hold: no step, no load, random inputs.
    for (int h = 0; h < 10; h++) begin
      ereset_n = 1'b1;
      step     = 1'b0;
      load     = 2'b00;
      v_init   = $urandom;
      i_in     = {$urandom, $urandom, $urandom, $urandom};
      @(posedge eclk);
      #1;
      chk($sformatf("hold_v[%0d]", h), v, {16'sd101, 16'sd7});
      chk($sformatf("hold_sat[%0d]", h), 32'(sat), 32'd0);
      chk($sformatf("hold_settled[%0d]", h), 32'(settled), 32'd1);
    end

    // Load colliding with a zero-current step must still clear node0's settle count.
    drive(1'b1, 1'b1, 2'b01, -3, 0, 0, 0, 0, 0, 0);
    chk("coll_v", v, {16'sd101, -16'sd3});
    chk("coll_settled", 32'(settled), 32'd0);
    chk("coll_p", 32'(p), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
